asa_riscv_seq_div: RTL and testbench

- Multi-cycle RV32M divide/remainder responder for the EX stage's divider port.
- The EX stage raises the valid strobe with a DIV/DIVU/REM/REMU operator and two operands, and stalls while busy is high.
- The unit computes the result by radix-2 restoring division and holds it until the EX stage acknowledges it.
- Divide-by-zero and signed overflow complete early with the RISC-V-mandated values.

---
 rtl/asa_riscv_seq_div.sv | 138 +++++++++++++
 tb/tb_asa_riscv_seq_div.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/asa_riscv_seq_div.sv
// Sequential RV32M divide/remainder unit for the EX-stage divider port.
// Radix-2 restoring division, one quotient bit per cycle, result held until acked.
module asa_riscv_seq_div #(
    parameter int XLEN         = 32,
    parameter int CNT_W        = 6,
    parameter int ALU_OP_WIDTH = 4,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 4'd12,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 4'd13,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_REM  = 4'd14,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_REMU = 4'd15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld_i,
    input  logic [ALU_OP_WIDTH-1:0] op_i,
    input  logic [XLEN-1:0]         opa_i,
    input  logic [XLEN-1:0]         opb_i,
    input  logic                    ack_i,
    input  logic                    flush_i,
    output logic                    busy_o,
    output logic                    bubble_o,
    output logic [XLEN-1:0]         result_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic neg_q;
        logic neg_r;
        logic rem;
    } op_flags_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    op_flags_t         flags;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   rem_acc;
    logic [XLEN-1:0]   quo;
    logic [CNT_W-1:0]  cnt;

    // Request decode
    logic            is_div, is_signed, is_rem;
    logic            accept, special, div0, ovf, last;
    logic [XLEN-1:0] a_abs, b_abs, special_res;

    always_comb begin
        is_div    = (op_i == ALU_DIV) || (op_i == ALU_DIVU) ||
                    (op_i == ALU_REM) || (op_i == ALU_REMU);
        is_signed = (op_i == ALU_DIV) || (op_i == ALU_REM);
        is_rem    = (op_i == ALU_REM) || (op_i == ALU_REMU);
        div0      = (opb_i == '0);
        ovf       = is_signed && (opa_i == INT_MIN) && (opb_i == '1);
        special   = div0 || ovf;
        a_abs     = (is_signed && opa_i[XLEN-1]) ? (~opa_i + 1'b1) : opa_i;
        b_abs     = (is_signed && opb_i[XLEN-1]) ? (~opb_i + 1'b1) : opb_i;
        if (div0)
            special_res = is_rem ? opa_i : '1;
        else
            special_res = is_rem ? '0 : INT_MIN;
        // flush wins over any new request, including the back-to-back path
        accept    = !flush_i && vld_i && is_div &&
                    ((state == IDLE) || ((state == DONE) && ack_i));
        last      = (cnt == CNT_W'(XLEN-1));
    end

    // One restoring step: shift {rem,quo}, trial-subtract with an extra carry bit
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] trial;
    logic            trial_neg;
    logic [XLEN-1:0] rem_nxt, quo_nxt, fix_res;

    always_comb begin
        rem_sh    = {rem_acc, quo[XLEN-1]};
        trial     = {1'b0, rem_sh} - {2'b00, divisor};
        trial_neg = trial[XLEN+1];
        rem_nxt   = trial_neg ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        quo_nxt   = {quo[XLEN-2:0], ~trial_neg};
        if (flags.rem)
            fix_res = flags.neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
        else
            fix_res = flags.neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_nxt = special ? DONE : CALC;
                CALC: if (last)   state_nxt = DONE;
                DONE: if (ack_i)  state_nxt = accept ? (special ? DONE : CALC) : IDLE;
                default:          state_nxt = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy_o   = ((state == IDLE) && vld_i && is_div) || (state == CALC);
        bubble_o = (state != DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags    <= '0;
            divisor  <= '0;
            rem_acc  <= '0;
            quo      <= '0;
            cnt      <= '0;
            result_o <= '0;
        end else if (accept) begin
            flags.neg_q <= is_signed && (opa_i[XLEN-1] ^ opb_i[XLEN-1]);
            flags.neg_r <= is_signed && opa_i[XLEN-1];
            flags.rem   <= is_rem;
            divisor     <= b_abs;
            quo         <= a_abs;
            rem_acc     <= '0;
            cnt         <= '0;
            if (special) result_o <= special_res;
        end else if (state == CALC && !flush_i) begin
            rem_acc <= rem_nxt;
            quo     <= quo_nxt;
            cnt     <= cnt + 1'b1;
            if (last) result_o <= fix_res;
        end
    end

endmodule

// File: tb/tb_asa_riscv_seq_div.sv
// Directed bench for asa_riscv_seq_div: vector table plus back-to-back, flush and reset sequences.
module tb_asa_riscv_seq_div;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REM  = 4'd14;
    localparam logic [3:0] OP_REMU = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld_i = 1'b0;
    logic [3:0]  op_i = '0;
    logic [31:0] opa_i = '0;
    logic [31:0] opb_i = '0;
    logic        ack_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        busy_o, bubble_o;
    logic [31:0] result_o;

    int checks = 0;
    int failures = 0;

    asa_riscv_seq_div #(
        .XLEN(32), .CNT_W(6), .ALU_OP_WIDTH(4),
        .ALU_DIV(OP_DIV), .ALU_DIVU(OP_DIVU), .ALU_REM(OP_REM), .ALU_REMU(OP_REMU)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .op_i(op_i),
        .opa_i(opa_i), .opb_i(opb_i), .ack_i(ack_i), .flush_i(flush_i),
        .busy_o(busy_o), .bubble_o(bubble_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Issue at a negedge; returns cycles until bubble_o falls (request cycle = 0).
    task automatic issue_and_wait(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input string name,
                                  output int lat, output logic busy_ok);
        vld_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
        #1;
        busy_ok = busy_o;
        @(negedge clk);
        vld_i = 1'b0; op_i = $urandom_range(15, 0); opa_i = $urandom; opb_i = $urandom;
        lat = 1;
        while (bubble_o && lat < 100) begin
            if (!busy_o) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) begin
            failures++; checks++;
            $display("FAIL %s_timeout: got no result expected result within 100 cycles", name);
        end
    endtask

    task automatic ack_result;
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
    endtask

    int          lat;
    logic        bok;
    logic        stayed;

    initial begin
        vecs.push_back('{"div_100_7",      OP_DIV,  32'd100,        32'd7,          32'd14,         33});
        vecs.push_back('{"rem_m7_2",       OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{"divu_max_2",     OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33});
        vecs.push_back('{"div_m100_7",     OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33});
        vecs.push_back('{"rem_m100_7",     OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33});
        vecs.push_back('{"rem_100_m7",     OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          33});
        vecs.push_back('{"div_0_5",        OP_DIV,  32'd0,          32'd5,          32'd0,          33});
        vecs.push_back('{"divu_min_max",   OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
        vecs.push_back('{"remu_min_max",   OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 33});
        vecs.push_back('{"divu_5_0",       OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{"remu_5_0",       OP_REMU, 32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{"div_5_0",        OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{"rem_m5_0",       OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1});
        vecs.push_back('{"div_ovf",        OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1});
        vecs.push_back('{"rem_ovf",        OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});

        #1;
        chk("reset_result", result_o, 32'd0);
        chk("reset_bubble", {31'd0, bubble_o}, 32'd1);
        chk("reset_busy",   {31'd0, busy_o},   32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Non-div op is ignored
        vld_i = 1'b1; op_i = OP_ADD; opa_i = 32'd10; opb_i = 32'd2;
        #1 chk("nondiv_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        vld_i = 1'b0;
        chk("nondiv_bubble", {31'd0, bubble_o}, 32'd1);

        foreach (vecs[i]) begin
            issue_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].name, lat, bok);
            chk({vecs[i].name, "_res"}, result_o, vecs[i].exp);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            chk({vecs[i].name, "_busy"}, {31'd0, bok}, 32'd1);
            if (i == 0) begin
                repeat (3) @(negedge clk);
                chk("hold_res", result_o, 32'd14);
                chk("hold_bubble", {31'd0, bubble_o}, 32'd0);
                chk("done_busy", {31'd0, busy_o}, 32'd0);
            end
            ack_result();
            chk({vecs[i].name, "_ack_idle"}, {31'd0, bubble_o}, 32'd1);
        end

        // Back-to-back: ack with a new request while in DONE
        issue_and_wait(OP_DIV, 32'd100, 32'd7, "b2b_first", lat, bok);
        chk("b2b_first_res", result_o, 32'd14);
        ack_i = 1'b1; vld_i = 1'b1; op_i = OP_DIV; opa_i = 32'd9; opb_i = 32'd3;
        #1 chk("b2b_done_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        ack_i = 1'b0; vld_i = 1'b0; opa_i = 32'd77; opb_i = 32'd1;
        chk("b2b_calc_busy", {31'd0, busy_o}, 32'd1);
        lat = 1;
        while (bubble_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_res", result_o, 32'd3);
        chk("b2b_lat", lat, 33);
        ack_result();

        // Flush at cycle 10 of a DIV
        vld_i = 1'b1; op_i = OP_DIV; opa_i = 32'd1000; opb_i = 32'd3;
        @(negedge clk);
        vld_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        chk("flush_bubble", {31'd0, bubble_o}, 32'd1);
        stayed = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (!bubble_o || busy_o) stayed = 1'b0;
        end
        chk("flush_no_result", {31'd0, stayed}, 32'd1);

        // Reset mid-CALC
        vld_i = 1'b1; op_i = OP_DIV; opa_i = 32'd1000; opb_i = 32'd3;
        @(negedge clk);
        vld_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_result", result_o, 32'd0);
        chk("rst_mid_bubble", {31'd0, bubble_o}, 32'd1);
        chk("rst_mid_busy",   {31'd0, busy_o},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stayed = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (!bubble_o) stayed = 1'b0;
        end
        chk("rst_no_result", {31'd0, stayed}, 32'd1);
        issue_and_wait(OP_DIVU, 32'd8, 32'd2, "post_rst", lat, bok);
        chk("post_rst_res", result_o, 32'd4);
        chk("post_rst_lat", lat, 33);
        ack_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
